period_detector: RTL

Measures the pitch of an incoming audio sample stream: it watches unsigned 16-bit samples arriving on the audio-rate enable strobe and detects mid-scale rising crossings with hysteresis. It counts audio ticks between successive rising crossings and reports the result as a half period in audio-clock ticks, in the same units the oscillator's `half_period` input uses. It sits on the receive side of the voice path, feeding tuner and display logic, and supports oscillator loop-back self-test.

---
 rtl/period_detector.sv | 107 ++++++++++
 1 files changed

// File: rtl/period_detector.sv
// period_detector: pitch measurement of a 16-bit audio stream via hysteretic mid-scale rising crossings.
// Ports:
//   clk          - system clock, all logic on the rising edge
//   reset        - asynchronous active-high reset
//   enable       - one-cycle audio sample strobe
//   sample_in    - unsigned 16-bit sample, valid while enable = 1
//   half_period  - last measured half period in audio ticks
//   period_valid - one-cycle pulse when half_period updates
//   locked       - two consecutive periods agreed within +/-1
//   timeout      - one-cycle pulse when no crossing arrived within the maximum period
module period_detector #(
    parameter logic [15:0] HYST = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] sample_in,
    output logic [15:0] half_period,
    output logic        period_valid,
    output logic        locked,
    output logic        timeout
);
    localparam logic [15:0] HI_TH   = 16'h8000 + HYST;
    localparam logic [15:0] LO_TH   = 16'h8000 - HYST;
    localparam logic [16:0] CNT_MAX = 17'h1FFFE;

    typedef enum logic [1:0] {ACQ, LOW, HIGH} state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] prev_q, prev_d;
    logic [15:0] half_q, half_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;

    logic        above, below, rise, meas, tout;
    logic [16:0] diff;

    assign above = sample_in >= HI_TH;
    assign below = sample_in <= LO_TH;
    assign rise  = enable && state_q == LOW && above;
    assign meas  = rise && armed_q;
    // a crossing on the last legal tick wins over the timeout
    assign tout  = enable && armed_q && !rise && cnt_q == CNT_MAX;
    assign diff  = cnt_q >= prev_q ? cnt_q - prev_q : prev_q - cnt_q;

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        half_d    = half_q;
        locked_d  = locked_q;
        valid_d   = meas;
        timeout_d = tout;
        // thresholds never overlap, so above and below are mutually exclusive
        if (enable)
            state_d = tout ? ACQ : above ? HIGH : below ? LOW : state_q;
        if (rise) begin
            cnt_d   = 17'd1;
            armed_d = 1'b1;
        end else if (tout) begin
            cnt_d   = 17'd0;
            armed_d = 1'b0;
        end else if (enable && armed_q) begin
            cnt_d = cnt_q + 17'd1;
        end
        if (meas) begin
            half_d   = 16'((cnt_q + 17'd1) >> 1);
            prev_d   = cnt_q;
            locked_d = prev_q != 17'd0 && diff <= 17'd1;
        end
        if (tout) begin
            locked_d = 1'b0;
            prev_d   = 17'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACQ;
            armed_q   <= 1'b0;
            cnt_q     <= 17'd0;
            prev_q    <= 17'd0;
            half_q    <= 16'd0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            half_q    <= half_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign half_period  = half_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
endmodule
